// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write arbiter.
//   - arbiter state encoding
//   - default DWIDTH / NREQ / MAX_LOCK
//   - clog2 helper used for index and counter widths
package fifo_arb_pkg;

  localparam int unsigned DEF_DWIDTH   = 4;
  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_MAX_LOCK = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: purely combinational rotating priority encoder.
// Ports:
//   req  in  NREQ  request vector
//   base in  IW    index searched first; search continues base+1, ... mod NREQ
//   gnt  out NREQ  one-hot winner (all zero when no request)
//   idx  out IW    winner index (0 when no request)
//   any  out 1     at least one request present
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   base,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // One extra bit so base+k cannot wrap before the modulo correction.
  logic [IW:0] w_pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, base} + (IW+1)'(k);
      if (w_pos >= (IW+1)'(NREQ)) w_pos = w_pos - (IW+1)'(NREQ);
      if (!any && req[w_pos[IW-1:0]]) begin
        any                 = 1'b1;
        gnt[w_pos[IW-1:0]] = 1'b1;
        idx                 = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NREQ producers, with bounded burst locking for contiguous writes.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   req        in   NREQ         per-requester write request
//   lock       in   NREQ         per-requester burst-lock request (sampled with req)
//   req_data   in   NREQ*DWIDTH  requester i data at [i*DWIDTH +: DWIDTH]
//   ack        out  NREQ         one-hot, word from requester i accepted this cycle
//   fifo_full  in   1            FIFO full; blocks any grant in the same cycle
//   fifo_wr_en out  1            FIFO write enable
//   fifo_data  out  DWIDTH       FIFO write data (0 when no write)
//   grant_id   out  clog2(NREQ)  index of acked requester (0 when no write)
//   locked     out  1            high while a burst owner holds the port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DWIDTH   = DEF_DWIDTH,
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        ack,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_data,
  output logic [clog2(NREQ)-1:0] grant_id,
  output logic                   locked
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned CW = clog2(MAX_LOCK + 1);

  arb_state_e      r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_lock_cnt;

  logic [NREQ-1:0] w_pick_gnt;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_any;

  logic            w_grant;
  logic [IW-1:0]   w_gid;
  logic [NREQ-1:0] w_ack;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_cap_hit;
  logic            w_lock_drop;

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .base (r_rr_ptr),
    .gnt  (w_pick_gnt),
    .idx  (w_pick_idx),
    .any  (w_pick_any)
  );

  // Grant is decided from registered state plus this cycle's inputs, so
  // fifo_full and reset suppress the write in the same cycle.
  always_comb begin
    w_grant = 1'b0;
    w_gid   = '0;
    w_ack   = '0;
    if (!reset && !fifo_full) begin
      if (r_state == ST_IDLE) begin
        w_grant = w_pick_any;
        w_gid   = w_pick_idx;
        w_ack   = w_pick_gnt;
      end else if (req[r_owner]) begin
        w_grant        = 1'b1;
        w_gid          = r_owner;
        w_ack[r_owner] = 1'b1;
      end
    end
  end

  // AND-OR mux keyed by the one-hot ack; yields 0 when nothing is granted.
  always_comb begin
    fifo_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_ack[i]) fifo_data = fifo_data | req_data[i*DWIDTH +: DWIDTH];
    end
  end

  assign w_cnt_inc   = r_lock_cnt + CW'(1);
  assign w_cap_hit   = w_grant && (w_cnt_inc == CW'(MAX_LOCK));
  assign w_lock_drop = !lock[r_owner];

  assign ack        = w_ack;
  assign fifo_wr_en = w_grant;
  assign grant_id   = w_gid;
  assign locked     = (r_state == ST_LOCKED) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_rr_ptr <= f_next(w_gid);
            // With MAX_LOCK=1 the first grant already reaches the cap, so
            // the lock is released on the same edge and LOCKED is skipped.
            if (lock[w_gid] && (MAX_LOCK > 1)) begin
              r_state    <= ST_LOCKED;
              r_owner    <= w_gid;
              r_lock_cnt <= CW'(1);
            end
          end
        end
        ST_LOCKED: begin
          // A lock drop coinciding with a grant still accepts the word
          // (ack is combinational) and leaves LOCKED on this edge.
          if (w_lock_drop || w_cap_hit) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= f_next(r_owner);
            r_lock_cnt <= '0;
          end else if (w_grant) begin
            r_lock_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: the driver pushes each expected
// grant when it applies a cycle's inputs; the monitor pops and compares
// whenever the arbiter writes to the FIFO.
module tb_fifo_wr_arbiter;

  localparam int DW    = 4;
  localparam int NR    = 4;
  localparam int ML    = 8;
  localparam int DEPTH = 8;
  localparam logic [NR*DW-1:0] DIR_DATA = 16'h4321; // requester i sends i+1

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR-1:0]    lock = '0;
  logic [NR*DW-1:0] req_data = DIR_DATA;
  logic [NR-1:0]    ack;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data;
  logic [1:0]       grant_id;
  logic             locked;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DWIDTH   (DW),
    .NREQ     (NR),
    .MAX_LOCK (ML)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .lock       (lock),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .grant_id   (grant_id),
    .locked     (locked)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int id;
    int data;
    int lk;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      chk("reset_ack", int'(ack), 0);
      chk("reset_wr_en", int'(fifo_wr_en), 0);
      chk("reset_data", int'(fifo_data), 0);
      chk("reset_grant_id", int'(grant_id), 0);
      chk("reset_locked", int'(locked), 0);
    end else begin
      if (fifo_full) begin
        chk("full_wr_en", int'(fifo_wr_en), 0);
        chk("full_ack", int'(ack), 0);
      end
      if (fifo_wr_en) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_write_grant_id", int'(grant_id), -1);
        end else begin
          e = sb_q.pop_front();
          chk("grant_id", int'(grant_id), e.id);
          chk("fifo_data", int'(fifo_data), e.data);
          chk("ack_onehot", int'(ack), 1 << e.id);
          chk("locked", int'(locked), e.lk);
        end
      end
    end
  end

  // One clock of stimulus; eid < 0 means no grant is expected.
  task automatic cyc(input logic rst, input logic [NR-1:0] r, input logic [NR-1:0] l,
                     input logic f, input logic [NR*DW-1:0] d,
                     input int eid, input int edata, input int elk);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    req       = r;
    lock      = l;
    fifo_full = f;
    req_data  = d;
    if (eid >= 0) begin
      e.id   = eid;
      e.data = edata;
      e.lk   = elk;
      sb_q.push_back(e);
    end
  endtask

  task automatic dcyc(input logic [NR-1:0] r, input logic [NR-1:0] l, input logic f,
                      input int eid, input int elk);
    cyc(1'b0, r, l, f, DIR_DATA, eid, eid + 1, elk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; req = '0; lock = '0; fifo_full = 1'b0; req_data = DIR_DATA;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic phase_end(input string nm);
    @(posedge clk);
    #1;
    req = '0; lock = '0; fifo_full = 1'b0;
    @(negedge clk);
    chk({nm, "_pending_grants"}, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Reference model state for the random phase.
  int m_lk, m_ptr, m_owner, m_cnt, fcnt;

  initial begin
    logic [NR-1:0]    r, l;
    logic [NR*DW-1:0] d;
    logic             f;
    int               gid, edata, elk;
    bit               pop;

    // Round robin over all four requesters.
    do_reset();
    for (int i = 0; i < 8; i++) dcyc(4'b1111, 4'b0000, 1'b0, i % 4, 0);
    phase_end("round_robin");

    // Idle requesters are skipped; pointer wraps 3 -> 0 -> picks 1.
    do_reset();
    for (int i = 0; i < 4; i++) dcyc(4'b1010, 4'b0000, 1'b0, (i % 2 == 0) ? 1 : 3, 0);
    phase_end("skip_idle");

    // Back-pressure after the grant to 1; next grant resumes at 2.
    do_reset();
    dcyc(4'b1111, 4'b0000, 1'b0, 0, 0);
    dcyc(4'b1111, 4'b0000, 1'b0, 1, 0);
    for (int i = 0; i < 3; i++) dcyc(4'b1111, 4'b0000, 1'b1, -1, 0);
    dcyc(4'b1111, 4'b0000, 1'b0, 2, 0);
    dcyc(4'b1111, 4'b0000, 1'b0, 3, 0);
    phase_end("back_pressure");

    // Burst lock by 0 for 4 cycles; the cycle lock drops still writes
    // owner 0's word, then IDLE resumes at 1.
    do_reset();
    for (int i = 0; i < 4; i++) dcyc(4'b0011, 4'b0001, 1'b0, 0, (i == 0) ? 0 : 1);
    dcyc(4'b0011, 4'b0000, 1'b0, 0, 1);
    dcyc(4'b0011, 4'b0000, 1'b0, 1, 0);
    dcyc(4'b0011, 4'b0000, 1'b0, 0, 0);
    phase_end("burst_lock");

    // Lock held: exactly MAX_LOCK grants to 0, then forced grant to 1.
    do_reset();
    for (int i = 0; i < ML; i++) dcyc(4'b0011, 4'b0001, 1'b0, 0, (i == 0) ? 0 : 1);
    dcyc(4'b0011, 4'b0001, 1'b0, 1, 0);
    dcyc(4'b0011, 4'b0001, 1'b0, 0, 0);
    phase_end("max_lock");

    // Reset while owner 2 holds the lock.
    do_reset();
    dcyc(4'b0100, 4'b0100, 1'b0, 2, 0);
    dcyc(4'b0100, 4'b0100, 1'b0, 2, 1);
    cyc(1'b1, 4'b0100, 4'b0100, 1'b0, DIR_DATA, -1, 0, 0);
    dcyc(4'b0110, 4'b0000, 1'b0, 1, 0);
    dcyc(4'b0110, 4'b0000, 1'b0, 2, 0);
    phase_end("reset_mid_lock");

    // Random traffic into a depth-8 FIFO model.
    do_reset();
    m_lk = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; fcnt = 0;
    for (int n = 0; n < 300; n++) begin
      r = NR'($urandom);
      l = NR'($urandom) & NR'($urandom);
      d = (NR*DW)'($urandom);
      f = (fcnt == DEPTH);
      gid = -1;
      if (!f) begin
        if (m_lk != 0) begin
          if (r[m_owner]) gid = m_owner;
        end else begin
          for (int k = 0; k < NR; k++) begin
            if (gid < 0 && r[(m_ptr + k) % NR]) gid = (m_ptr + k) % NR;
          end
        end
      end
      elk   = m_lk;
      edata = (gid >= 0) ? int'((d >> (gid * DW)) & 16'h000f) : 0;
      cyc(1'b0, r, l, f, d, gid, edata, elk);

      if (m_lk == 0) begin
        if (gid >= 0) begin
          m_ptr = (gid + 1) % NR;
          if (l[gid] && ML > 1) begin
            m_lk = 1; m_owner = gid; m_cnt = 1;
          end
        end
      end else begin
        if (gid >= 0) m_cnt++;
        if (!l[m_owner] || (gid >= 0 && m_cnt == ML)) begin
          m_lk  = 0;
          m_ptr = (m_owner + 1) % NR;
        end
      end
      pop  = (fcnt > 0) && ($urandom_range(0, 2) == 0);
      fcnt = fcnt + ((gid >= 0) ? 1 : 0) - (pop ? 1 : 0);
    end
    phase_end("random_fifo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
